patch_read_scheduler: RTL and testbench
=======================================

PATCH_READ_SCHEDULER -- requirements
Module: patch_read_scheduler

Interface
REQ-001 SHALL have parameter DIMENSION, default 64, meaning octave-1 image width/height in pixels.
REQ-002 SHALL have parameter PATCH_SIZE, default 4, meaning patch edge length in pixels, an even power of two.
REQ-003 SHALL have parameter BIT_DEPTH, default 8, meaning signed gradient sample width.
REQ-004 SHALL have parameter READ_LATENCY, default 2, meaning gradient BRAM address-to-data latency in cycles.
REQ-005 SHALL have port clk, input, 1, meaning single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, meaning a keypoint request, accepted only while ready=1.
REQ-008 SHALL have port ready, output, 1, meaning idle and able to accept start.
REQ-009 SHALL have port kp_x and port kp_y, input, $clog2(DIMENSION) each, meaning keypoint coordinates in octave pixels.
REQ-010 SHALL have port kp_octave, input, 2, meaning octave 0..2; value 3 is illegal.
REQ-011 SHALL have port kp_level, input, 1, meaning gradient level within the octave.
REQ-012 SHALL have port rd_addr, output, $clog2(DIMENSION*DIMENSION), meaning the shared gradient BRAM read address.
REQ-013 SHALL have port rd_sel, output, 6, meaning one-hot BRAM select, bit = 2*octave+level; all zero when no read is issued.
REQ-014 SHALL have port grad_x_in and port grad_y_in, input, 6*BIT_DEPTH each, meaning packed BRAM outputs, slice k = BRAM k.
REQ-015 SHALL have port grad_valid, output, 1, meaning grad_x/grad_y/sub_idx/pix_idx are valid this cycle.
REQ-016 SHALL have port grad_x and port grad_y, output, BIT_DEPTH signed each, meaning the selected gradient sample.
REQ-017 SHALL have port sub_idx, output, 2, meaning sub-patch number {row>=P/2, col>=P/2}.
REQ-018 SHALL have port pix_idx, output, $clog2(PATCH_SIZE*PATCH_SIZE), meaning raster position in the patch.
REQ-019 SHALL have port patch_done, output, 1, meaning a one-cycle pulse with the last sample.
REQ-020 SHALL have port kp_error, output, 1, meaning a one-cycle pulse on illegal octave.

Function
REQ-021 SHALL have states IDLE, ISSUE, DRAIN; ready=1 only in IDLE; start outside IDLE is ignored.
REQ-022 SHALL, on start in IDLE with octave<=2, register the inputs and go to ISSUE; with octave=3, pulse kp_error next cycle, issue no reads and stay in IDLE.
REQ-023 SHALL use W = DIMENSION>>octave and compute origin ox = clamp(kp_x-P/2, 0, W-P), oy likewise; the subtraction SHALL be signed so that underflow clamps to 0.
REQ-024 SHALL, in ISSUE, issue one read per cycle for P*P cycles in row-major order, with rd_addr = (oy+r)*W + (ox+c) and rd_sel = the one-hot select; the first read SHALL occur the cycle after start.
REQ-025 SHALL go to DRAIN after the last issue, and return to IDLE in the cycle patch_done is asserted.
REQ-026 SHALL carry a valid/sel/index tag through a READ_LATENCY-deep shift register, and SHALL emit grad_valid with the slice chosen by the delayed sel, READ_LATENCY cycles after each issue.
REQ-027 SHALL provide latency: start at cycle 0; first grad_valid at cycle 1+READ_LATENCY; patch_done with the last sample at cycle P*P+READ_LATENCY; ready=1 the following cycle.
REQ-028 SHALL have no backpressure; the consumer accepts every grad_valid cycle.
REQ-029 SHALL hold rd_addr/grad_x/grad_y at their last values when idle; rd_sel and grad_valid SHALL be zero.

Reset
REQ-030 SHALL, on rst_in low at any time (including mid-patch), immediately set state IDLE, ready=1, rd_sel=0, grad_valid=0, patch_done=0, kp_error=0, rd_addr=0, grad_x=grad_y=0, sub_idx=pix_idx=0, and clear the tag pipeline; no stale sample SHALL emerge after release.

Verification
REQ-031 SHALL cover: octave0 level0 x=10 y=20 -> rd_sel=000001; addrs 1160..1163, 1224.., last 1355; 16 grad_valid; patch_done at cycle 18.
REQ-032 SHALL cover: octave1 level1 x=0 y=31 -> origin (0,28); rd_sel=001000; first addr 896, last 995.
REQ-033 SHALL cover: octave2 level0 x=15 y=1 -> origin (12,0); rd_sel=010000; first addr 12, last 63; sub_idx sequence 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3.
REQ-034 SHALL cover: start with octave=3 -> kp_error pulse, rd_sel stays 0, ready stays 1.
REQ-035 SHALL cover: start pulsed during ISSUE -> ignored, exactly 16 samples from the first request.
REQ-036 SHALL cover: rst_in low at issue 7 -> outputs reset at once; no grad_valid after release; a new start then runs a full 16-sample patch.

Source files
------------

// File: rtl/patch_read_scheduler_if.sv
// Keypoint request, gradient BRAM read port and patch sample stream of the
// patch read scheduler, bundled for a single module port.
interface patch_read_scheduler_if #(
    parameter int DIMENSION  = 64,
    parameter int PATCH_SIZE = 4,
    parameter int BIT_DEPTH  = 8
);
    localparam int XW = $clog2(DIMENSION);
    localparam int AW = $clog2(DIMENSION * DIMENSION);
    localparam int PW = $clog2(PATCH_SIZE * PATCH_SIZE);

    logic                        start;
    logic                        ready;
    logic [XW-1:0]               kp_x;
    logic [XW-1:0]               kp_y;
    logic [1:0]                  kp_octave;
    logic                        kp_level;
    logic [AW-1:0]               rd_addr;
    logic [5:0]                  rd_sel;
    logic [6*BIT_DEPTH-1:0]      grad_x_in;
    logic [6*BIT_DEPTH-1:0]      grad_y_in;
    logic                        grad_valid;
    logic signed [BIT_DEPTH-1:0] grad_x;
    logic signed [BIT_DEPTH-1:0] grad_y;
    logic [1:0]                  sub_idx;
    logic [PW-1:0]               pix_idx;
    logic                        patch_done;
    logic                        kp_error;

    modport master (
        input  start, kp_x, kp_y, kp_octave, kp_level, grad_x_in, grad_y_in,
        output ready, rd_addr, rd_sel, grad_valid, grad_x, grad_y,
               sub_idx, pix_idx, patch_done, kp_error
    );

    modport slave (
        output start, kp_x, kp_y, kp_octave, kp_level, grad_x_in, grad_y_in,
        input  ready, rd_addr, rd_sel, grad_valid, grad_x, grad_y,
               sub_idx, pix_idx, patch_done, kp_error
    );
endinterface

// File: rtl/patch_read_scheduler.sv
// Reads a PATCH_SIZE x PATCH_SIZE gradient patch around a keypoint from one of
// six shared-address gradient BRAMs and streams the samples with their indices.
module patch_read_scheduler #(
    parameter int DIMENSION    = 64,
    parameter int PATCH_SIZE   = 4,
    parameter int BIT_DEPTH    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_in,
    patch_read_scheduler_if.master bus
);
    localparam int XW = $clog2(DIMENSION);
    localparam int AW = $clog2(DIMENSION * DIMENSION);
    localparam int PW = $clog2(PATCH_SIZE * PATCH_SIZE);
    localparam int CW = $clog2(PATCH_SIZE);
    localparam int L  = READ_LATENCY;
    localparam logic [PW-1:0] LAST_PIX = PW'(PATCH_SIZE * PATCH_SIZE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t state, state_nxt;
    logic ready_c, accept, bad_req;
    logic [XW-1:0] ox_c, oy_c;
    logic [AW-1:0] first_addr_c, row_step_c;
    logic [AW-1:0] addr_p0, row_step;
    logic          vld_p [L];
    logic [5:0]    sel_p [L];
    logic [PW-1:0] pix_p [L];
    logic signed [BIT_DEPTH-1:0] gx_mux, gy_mux, gx_r, gy_r;
    logic          vld_r, done_r, err_r;
    logic [1:0]    sub_r;
    logic [PW-1:0] pix_r;

    // Signed subtraction so a keypoint near the low edge clamps to 0 instead of wrapping.
    function automatic logic [XW-1:0] clamp_origin(input logic [XW-1:0] kp, input logic [1:0] oct);
        logic signed [XW+1:0] v;
        logic signed [XW+1:0] hi;
        v  = $signed({2'b00, kp}) - (XW+2)'(PATCH_SIZE / 2);
        hi = (XW+2)'((DIMENSION >> oct) - PATCH_SIZE);
        if (v < 0)
            clamp_origin = '0;
        else if (v > hi)
            clamp_origin = hi[XW-1:0];
        else
            clamp_origin = v[XW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (pix_p[0] == LAST_PIX) state_nxt = DRAIN;
            DRAIN:   if (done_r) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_c = (state == IDLE);
        accept  = ready_c && bus.start && (bus.kp_octave != 2'd3);
        bad_req = ready_c && bus.start && (bus.kp_octave == 2'd3);
    end

    always_comb begin
        ox_c         = clamp_origin(bus.kp_x, bus.kp_octave);
        oy_c         = clamp_origin(bus.kp_y, bus.kp_octave);
        first_addr_c = (AW'(oy_c) << (XW - int'(bus.kp_octave))) + AW'(ox_c);
        row_step_c   = AW'((DIMENSION >> bus.kp_octave) - PATCH_SIZE + 1);
    end

    always_comb begin
        gx_mux = '0;
        gy_mux = '0;
        for (int k = 0; k < 6; k++) begin
            if (sel_p[L-1][k]) begin
                gx_mux = $signed(bus.grad_x_in[k*BIT_DEPTH +: BIT_DEPTH]);
                gy_mux = $signed(bus.grad_y_in[k*BIT_DEPTH +: BIT_DEPTH]);
            end
        end
    end

    // Stage 0: address issue; stages 1..L-1: tag delay matching the BRAM latency
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            addr_p0  <= '0;
            row_step <= '0;
            for (int i = 0; i < L; i++) begin
                vld_p[i] <= 1'b0;
                sel_p[i] <= '0;
                pix_p[i] <= '0;
            end
        end else begin
            for (int i = 1; i < L; i++) begin
                vld_p[i] <= vld_p[i-1];
                sel_p[i] <= sel_p[i-1];
                pix_p[i] <= pix_p[i-1];
            end
            if (accept) begin
                addr_p0  <= first_addr_c;
                row_step <= row_step_c;
                vld_p[0] <= 1'b1;
                sel_p[0] <= 6'd1 << {bus.kp_octave, bus.kp_level};
                pix_p[0] <= '0;
            end else if (state == ISSUE) begin
                if (pix_p[0] == LAST_PIX) begin
                    vld_p[0] <= 1'b0;
                    sel_p[0] <= '0;
                end else begin
                    pix_p[0] <= pix_p[0] + 1'b1;
                    addr_p0  <= (&pix_p[0][CW-1:0]) ? addr_p0 + row_step : addr_p0 + 1'b1;
                end
            end
        end
    end

    // Output stage: sample selected by the delayed one-hot select
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            vld_r  <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            gx_r   <= '0;
            gy_r   <= '0;
            sub_r  <= '0;
            pix_r  <= '0;
        end else begin
            vld_r  <= vld_p[L-1];
            done_r <= vld_p[L-1] && (pix_p[L-1] == LAST_PIX);
            err_r  <= bad_req;
            if (vld_p[L-1]) begin
                gx_r  <= gx_mux;
                gy_r  <= gy_mux;
                pix_r <= pix_p[L-1];
                sub_r <= {pix_p[L-1][PW-1], pix_p[L-1][CW-1]};
            end
        end
    end

    assign bus.ready      = ready_c;
    assign bus.rd_addr    = addr_p0;
    assign bus.rd_sel     = sel_p[0];
    assign bus.grad_valid = vld_r;
    assign bus.grad_x     = gx_r;
    assign bus.grad_y     = gy_r;
    assign bus.sub_idx    = sub_r;
    assign bus.pix_idx    = pix_r;
    assign bus.patch_done = done_r;
    assign bus.kp_error   = err_r;
endmodule

// File: tb/tb_patch_read_scheduler.sv
// Bench for patch_read_scheduler: directed and random keypoints against a
// coordinate-level patch model, with a behavioural gradient BRAM.
module tb_patch_read_scheduler;
    localparam int DIM  = 64;
    localparam int P    = 4;
    localparam int BD   = 8;
    localparam int RL   = 2;
    localparam int NPIX = P * P;

    logic clk = 1'b0;
    logic rst_in;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    patch_read_scheduler_if #(.DIMENSION(DIM), .PATCH_SIZE(P), .BIT_DEPTH(BD)) bus ();

    patch_read_scheduler #(
        .DIMENSION(DIM), .PATCH_SIZE(P), .BIT_DEPTH(BD), .READ_LATENCY(RL)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .bus(bus)
    );

    function automatic logic [7:0] bram_gx(input int k, input int a);
        return 8'(a * 7 + k * 37 + 5);
    endfunction

    function automatic logic [7:0] bram_gy(input int k, input int a);
        return 8'((a * 11) ^ (k * 53) ^ 90);
    endfunction

    function automatic int ref_origin(input int c, input int oct);
        int w, v;
        w = DIM >> oct;
        v = c - P / 2;
        if (v < 0) v = 0;
        if (v > w - P) v = w - P;
        return v;
    endfunction

    // Behavioural BRAM: data for an address appears RL edges after it is presented.
    logic [11:0] addr_hist [RL-1];
    always @(posedge clk) begin
        addr_hist[0] <= bus.rd_addr;
        for (int i = 1; i < RL - 1; i++) addr_hist[i] <= addr_hist[i-1];
    end

    always_comb begin
        bus.grad_x_in = '0;
        bus.grad_y_in = '0;
        for (int k = 0; k < 6; k++) begin
            bus.grad_x_in[k*BD +: BD] = bram_gx(k, int'(addr_hist[RL-2]));
            bus.grad_y_in[k*BD +: BD] = bram_gy(k, int'(addr_hist[RL-2]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        bus.start = 1'b0;
        bus.kp_x = '0;
        bus.kp_y = '0;
        bus.kp_octave = '0;
        bus.kp_level = 1'b0;
        step();
        step();
        n_checks++;
        if (bus.ready !== 1'b1 || bus.rd_sel !== 6'b0 || bus.grad_valid !== 1'b0 ||
            bus.patch_done !== 1'b0 || bus.kp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl ready=%b rd_sel=%b grad_valid=%b done=%b err=%b expected 1 000000 0 0 0",
                     bus.ready, bus.rd_sel, bus.grad_valid, bus.patch_done, bus.kp_error);
        end
        n_checks++;
        if (bus.rd_addr !== 12'd0 || bus.grad_x !== 8'sd0 || bus.grad_y !== 8'sd0 ||
            bus.sub_idx !== 2'd0 || bus.pix_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_data addr=%0d gx=%0d gy=%0d sub=%0d pix=%0d expected all 0",
                     bus.rd_addr, bus.grad_x, bus.grad_y, bus.sub_idx, bus.pix_idx);
        end
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_patch(input int x, input int y, input int oct, input int lvl,
                              output int first_a, output int last_a, output int done_cyc,
                              output logic [31:0] subs);
        int ox, oy, w, k, ea;
        logic [11:0] e_addr;
        logic [5:0]  e_sel;
        logic [7:0]  e_gx, e_gy;
        logic [1:0]  e_sub;
        ox = ref_origin(x, oct);
        oy = ref_origin(y, oct);
        w = DIM >> oct;
        e_sel = 6'(1 << (2 * oct + lvl));
        first_a = -1; last_a = -1; done_cyc = -1; subs = '0;
        n_checks++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL patch_ready_before ready=%b expected 1", bus.ready);
        end
        bus.start = 1'b1;
        bus.kp_x = 6'(x);
        bus.kp_y = 6'(y);
        bus.kp_octave = 2'(oct);
        bus.kp_level = 1'(lvl);
        for (int t = 1; t <= NPIX + RL + 1; t++) begin
            step();
            if (t == 1) bus.start = 1'b0;
            if (t <= NPIX) begin
                k = t - 1;
                e_addr = 12'((oy + k / P) * w + ox + k % P);
                n_checks++;
                if (bus.rd_sel !== e_sel || bus.rd_addr !== e_addr) begin
                    n_fail++;
                    $display("FAIL patch_issue t=%0d sel=%b addr=%0d expected sel=%b addr=%0d",
                             t, bus.rd_sel, bus.rd_addr, e_sel, e_addr);
                end
                if (t == 1) first_a = int'(bus.rd_addr);
                if (t == NPIX) last_a = int'(bus.rd_addr);
            end else begin
                n_checks++;
                if (bus.rd_sel !== 6'b0) begin
                    n_fail++;
                    $display("FAIL patch_sel_idle t=%0d sel=%b expected 000000", t, bus.rd_sel);
                end
            end
            if (t >= 1 + RL && t <= NPIX + RL) begin
                k = t - 1 - RL;
                ea = (oy + k / P) * w + ox + k % P;
                e_gx = bram_gx(2 * oct + lvl, ea);
                e_gy = bram_gy(2 * oct + lvl, ea);
                e_sub = {(k / P) >= P / 2, (k % P) >= P / 2};
                n_checks++;
                if (bus.grad_valid !== 1'b1 || bus.grad_x !== e_gx || bus.grad_y !== e_gy ||
                    bus.sub_idx !== e_sub || bus.pix_idx !== 4'(k)) begin
                    n_fail++;
                    $display("FAIL patch_sample t=%0d vld=%b gx=%h gy=%h sub=%0d pix=%0d expected 1 %h %h %0d %0d",
                             t, bus.grad_valid, bus.grad_x, bus.grad_y, bus.sub_idx, bus.pix_idx,
                             e_gx, e_gy, e_sub, k);
                end
                subs[2*k +: 2] = bus.sub_idx;
            end else begin
                n_checks++;
                if (bus.grad_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL patch_valid_idle t=%0d vld=%b expected 0", t, bus.grad_valid);
                end
            end
            if (bus.patch_done === 1'b1 && done_cyc < 0) done_cyc = t;
            n_checks++;
            if (bus.patch_done !== (t == NPIX + RL) || bus.ready !== (t == NPIX + RL + 1) ||
                bus.kp_error !== 1'b0) begin
                n_fail++;
                $display("FAIL patch_ctrl t=%0d done=%b ready=%b err=%b expected %b %b 0",
                         t, bus.patch_done, bus.ready, bus.kp_error,
                         (t == NPIX + RL), (t == NPIX + RL + 1));
            end
        end
    endtask

    task automatic test_directed();
        int fa, la, dc;
        logic [31:0] subs, e_subs;
        int seq [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
        test_patch(10, 20, 0, 0, fa, la, dc, subs);
        n_checks++;
        if (fa != 1160 || la != 1355 || dc != 18) begin
            n_fail++;
            $display("FAIL directed_o0 first=%0d last=%0d done=%0d expected 1160 1355 18", fa, la, dc);
        end
        test_patch(0, 31, 1, 1, fa, la, dc, subs);
        n_checks++;
        if (fa != 896 || la != 995) begin
            n_fail++;
            $display("FAIL directed_o1 first=%0d last=%0d expected 896 995", fa, la);
        end
        test_patch(15, 1, 2, 0, fa, la, dc, subs);
        e_subs = '0;
        for (int i = 0; i < 16; i++) e_subs[2*i +: 2] = 2'(seq[i]);
        n_checks++;
        if (fa != 12 || la != 63 || subs !== e_subs) begin
            n_fail++;
            $display("FAIL directed_o2 first=%0d last=%0d subs=%h expected 12 63 %h", fa, la, subs, e_subs);
        end
    endtask

    task automatic test_bad_octave();
        int stray;
        bus.start = 1'b1;
        bus.kp_x = 6'd5;
        bus.kp_y = 6'd5;
        bus.kp_octave = 2'd3;
        bus.kp_level = 1'b0;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.kp_error !== 1'b1 || bus.ready !== 1'b1 || bus.rd_sel !== 6'b0) begin
            n_fail++;
            $display("FAIL bad_octave_pulse err=%b ready=%b sel=%b expected 1 1 000000",
                     bus.kp_error, bus.ready, bus.rd_sel);
        end
        stray = 0;
        for (int t = 0; t < 6; t++) begin
            step();
            if (bus.kp_error !== 1'b0 || bus.rd_sel !== 6'b0 || bus.grad_valid !== 1'b0 ||
                bus.ready !== 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL bad_octave_after stray_cycles=%0d expected 0", stray);
        end
    endtask

    task automatic test_start_ignored();
        int n_iss, n_vld, bad, ea;
        n_iss = 0; n_vld = 0; bad = 0;
        bus.start = 1'b1;
        bus.kp_x = 6'd30;
        bus.kp_y = 6'd30;
        bus.kp_octave = 2'd0;
        bus.kp_level = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (t == 1) bus.start = 1'b0;
            if (t == 5) begin
                bus.start = 1'b1;
                bus.kp_x = 6'd3;
                bus.kp_y = 6'd50;
                bus.kp_octave = 2'd1;
                bus.kp_level = 1'b1;
            end
            if (t == 6) bus.start = 1'b0;
            if (bus.rd_sel !== 6'b0) begin
                ea = (28 + n_iss / P) * DIM + 28 + n_iss % P;
                if (bus.rd_sel !== 6'b000001 || bus.rd_addr !== 12'(ea)) bad++;
                n_iss++;
            end
            if (bus.grad_valid === 1'b1) begin
                ea = (28 + n_vld / P) * DIM + 28 + n_vld % P;
                if (bus.grad_x !== bram_gx(0, ea) || bus.pix_idx !== 4'(n_vld)) bad++;
                n_vld++;
            end
        end
        n_checks++;
        if (n_iss != 16 || n_vld != 16 || bad != 0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ignored issues=%0d samples=%0d bad=%0d ready=%b expected 16 16 0 1",
                     n_iss, n_vld, bad, bus.ready);
        end
    endtask

    task automatic test_reset_mid_patch();
        int stray, fa, la, dc;
        logic [31:0] subs;
        bus.start = 1'b1;
        bus.kp_x = 6'd20;
        bus.kp_y = 6'd10;
        bus.kp_octave = 2'd1;
        bus.kp_level = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t == 1) bus.start = 1'b0;
        end
        n_checks++;
        if (bus.rd_addr !== 12'((8 + 1) * 32 + 18 + 3) || bus.rd_sel !== 6'b000100) begin
            n_fail++;
            $display("FAIL midreset_issue7 addr=%0d sel=%b expected %0d 000100",
                     bus.rd_addr, bus.rd_sel, (8 + 1) * 32 + 18 + 3);
        end
        rst_in = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.rd_sel !== 6'b0 || bus.grad_valid !== 1'b0 ||
            bus.rd_addr !== 12'd0 || bus.grad_x !== 8'sd0 || bus.grad_y !== 8'sd0 ||
            bus.pix_idx !== 4'd0 || bus.sub_idx !== 2'd0 || bus.patch_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async ready=%b sel=%b vld=%b addr=%0d gx=%0d gy=%0d pix=%0d sub=%0d done=%b expected 1 0 0 0 0 0 0 0 0",
                     bus.ready, bus.rd_sel, bus.grad_valid, bus.rd_addr, bus.grad_x, bus.grad_y,
                     bus.pix_idx, bus.sub_idx, bus.patch_done);
        end
        step();
        rst_in = 1'b1;
        stray = 0;
        for (int t = 0; t < 25; t++) begin
            step();
            if (bus.grad_valid !== 1'b0 || bus.rd_sel !== 6'b0 || bus.patch_done !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL midreset_stale stray_cycles=%0d expected 0", stray);
        end
        test_patch(40, 5, 0, 1, fa, la, dc, subs);
        n_checks++;
        if (dc != NPIX + RL) begin
            n_fail++;
            $display("FAIL midreset_restart done_cycle=%0d expected %0d", dc, NPIX + RL);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa, la, dc, oct, w;
        logic [31:0] subs;
        test_reset();
        test_directed();
        test_bad_octave();
        test_start_ignored();
        test_reset_mid_patch();
        for (int n = 0; n < 8; n++) begin
            oct = int'($urandom_range(0, 2));
            w = DIM >> oct;
            test_patch(int'($urandom_range(0, w - 1)), int'($urandom_range(0, w - 1)), oct,
                       int'($urandom_range(0, 1)), fa, la, dc, subs);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
